if_fetch: RTL and testbench

//  Instruction-fetch stage. Generates sequential PCs, issues requests to

---
 rtl/if_fetch.sv | 168 ++++++++++++++++
 tb/tb_if_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage. It generates sequential PCs and issues one
// request per word to instruction memory. Returned words are buffered in an
// in-order FIFO, and the stage drives the registered {pc, inst} pair that
// the decode stage consumes. Pipeline control can stall decode, or it can
// redirect fetch to a new PC. A redirect discards every fetch still in flight.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active-low (0 = reset)
//   stall_i        in   1   1 = hold decode outputs
//   redirect_i     in   1   1 = restart fetch at redirect_pc_i
//   redirect_pc_i  in   32  new PC, word aligned
//   imem_req_o     out  1   fetch request, one-cycle pulse per word
//   imem_addr_o    out  32  fetch address, valid while imem_req_o=1
//   imem_ack_i     in   1   returned word valid
//   imem_rdata_i   in   32  returned instruction word
//   id_pc_o        out  32  PC of the instruction presented to decode
//   id_inst_o      out  32  instruction presented to decode
//   id_valid_o     out  1   1 = id_pc_o/id_inst_o hold a real fetch
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]   DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      pc;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] fifo_wr_ptr;
    logic [PTR_W-1:0] fifo_rd_ptr;
    logic [PTR_W-1:0] pcq_wr_ptr;
    logic [PTR_W-1:0] pcq_rd_ptr;

    logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
    logic [31:0] fifo_inst_mem [FIFO_DEPTH];
    logic [31:0] pcq_mem       [FIFO_DEPTH];

    logic [CNT_W:0] credit_used;
    logic           issue;
    logic           ack_ok;
    logic           ack_keep;
    logic           ack_drop;
    logic           fifo_empty;
    logic           do_pop;

    // The in-flight and buffered words together may never exceed the FIFO
    // depth. Every outstanding ack therefore has a free FIFO slot, even if
    // decode stalls for a long time. A stray ack with nothing outstanding
    // is ignored. The PC queue holds entries only for acks that will be
    // kept. Dropped acks therefore do not touch it.
    always_comb begin
        credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
        issue       = rst & ~redirect_i & (credit_used < DEPTH_V);
        ack_ok      = imem_ack_i & (out_cnt != '0);
        ack_keep    = ack_ok & (drop_cnt == '0) & ~redirect_i;
        ack_drop    = ack_ok & (drop_cnt != '0);
        fifo_empty  = (fifo_cnt == '0);
        do_pop      = ~stall_i & ~fifo_empty & ~redirect_i;
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = pc;

    // Control state: fetch PC, outstanding and drop counters, queue
    // pointers, and the decode register. A redirect flushes both queues.
    // Every request still outstanding, minus one acked in this same cycle,
    // becomes a word that must be dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            out_cnt     <= '0;
            drop_cnt    <= '0;
            fifo_cnt    <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            pcq_wr_ptr  <= '0;
            pcq_rd_ptr  <= '0;
            id_pc_o     <= '0;
            id_inst_o   <= '0;
            id_valid_o  <= 1'b0;
        end else begin
            if (issue && !ack_ok) begin
                out_cnt <= out_cnt + CNT_ONE;
            end else if (!issue && ack_ok) begin
                out_cnt <= out_cnt - CNT_ONE;
            end

            if (redirect_i) begin
                pc          <= redirect_pc_i;
                drop_cnt    <= out_cnt - (ack_ok ? CNT_ONE : '0);
                fifo_cnt    <= '0;
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
                pcq_wr_ptr  <= '0;
                pcq_rd_ptr  <= '0;
            end else begin
                if (issue) begin
                    pc         <= pc + 32'd4;
                    pcq_wr_ptr <= pcq_wr_ptr + PTR_ONE;
                end
                if (ack_keep) begin
                    pcq_rd_ptr  <= pcq_rd_ptr + PTR_ONE;
                    fifo_wr_ptr <= fifo_wr_ptr + PTR_ONE;
                end
                if (ack_drop) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                if (do_pop) begin
                    fifo_rd_ptr <= fifo_rd_ptr + PTR_ONE;
                end
                if (ack_keep && !do_pop) begin
                    fifo_cnt <= fifo_cnt + CNT_ONE;
                end else if (!ack_keep && do_pop) begin
                    fifo_cnt <= fifo_cnt - CNT_ONE;
                end
            end

            if (!stall_i) begin
                if (do_pop) begin
                    id_pc_o    <= fifo_pc_mem[fifo_rd_ptr];
                    id_inst_o  <= fifo_inst_mem[fifo_rd_ptr];
                    id_valid_o <= 1'b1;
                end else begin
                    id_pc_o    <= '0;
                    id_inst_o  <= '0;
                    id_valid_o <= 1'b0;
                end
            end
        end
    end

    // Queue storage. It needs no reset, because the pointers and counts
    // above decide which entries are live.
    always_ff @(posedge clk) begin
        if (issue) begin
            pcq_mem[pcq_wr_ptr] <= pc;
        end
        if (ack_keep) begin
            fifo_pc_mem[fifo_wr_ptr]   <= pcq_mem[pcq_rd_ptr];
            fifo_inst_mem[fifo_wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//
// Testbench for if_fetch. A memory model answers requests in order with a
// configurable latency. A reference model tracks in-flight requests and
// buffered words as plain queues, and predicts the request line and the
// decode outputs every cycle. Directed scenarios come first: reset release,
// a stall, redirects, address wrap and reset mid-stream. A randomized phase
// follows.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    req_t        pend[$];
    word_t       buf_q[$];
    logic [31:0] req_log[$];
    logic [31:0] m_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_valid;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    bit          inject_stray;
    int          checks;
    int          errors;

    // Contents of instruction memory, derived from the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9601;
    endfunction

    // Compares one observed value with its expected value and counts the check.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Puts the model back into its reset state.
    task automatic model_reset();
        pend.delete();
        buf_q.delete();
        m_pc      = RESET_PC;
        exp_pc    = '0;
        exp_inst  = '0;
        exp_valid = 1'b0;
        last_due  = cyc;
    endtask

    // Runs one clock cycle. It is entered 1 ns after a rising edge. It drives
    // the inputs and the memory response, and checks the request and decode
    // outputs mid-cycle. It then advances the model across the edge.
    task automatic apply_stimulus(input bit st, input bit rd, input logic [31:0] tgt);
        bit          ack;
        bit          exp_req;
        bit          pop;
        int          due;
        req_t        e;
        logic [31:0] a;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        ack = (pend.size() > 0) && (pend[0].due <= cyc);
        if (inject_stray) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
            inject_stray = 1'b0;
        end else begin
            imem_ack_i   = ack;
            imem_rdata_i = ack ? mem_word(pend[0].addr) : $urandom();
        end
        exp_req = (rst === 1'b1) && !rd && (pend.size() + buf_q.size() < DEPTH);
        #3;
        if (imem_req_o === 1'b1) req_log.push_back(imem_addr_o);
        check_output("req", {31'b0, imem_req_o}, {31'b0, exp_req});
        if (exp_req) check_output("req_addr", imem_addr_o, m_pc);
        check_output("id_valid", {31'b0, id_valid_o}, {31'b0, exp_valid});
        check_output("id_pc", id_pc_o, exp_pc);
        check_output("id_inst", id_inst_o, exp_inst);
        if (rst === 1'b1) begin
            pop = !st && !rd && (buf_q.size() > 0);
            if (!st) begin
                if (pop) begin
                    exp_pc    = buf_q[0].pc;
                    exp_inst  = buf_q[0].inst;
                    exp_valid = 1'b1;
                end else begin
                    exp_pc    = '0;
                    exp_inst  = '0;
                    exp_valid = 1'b0;
                end
            end
            if (pop) void'(buf_q.pop_front());
            if (ack) begin
                e = pend.pop_front();
                if (!rd && !e.stale) buf_q.push_back('{e.addr, mem_word(e.addr)});
            end
            if (exp_req) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                a = m_pc;
                pend.push_back('{a, due, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (rd) begin
                m_pc = tgt;
                buf_q.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs idle cycles until decode shows a valid word, with a cycle limit.
    // It then checks which PC arrived.
    task automatic wait_valid(input string tag, input logic [31:0] want_pc);
        int n;
        n = 0;
        while (id_valid_o !== 1'b1 && n < 30) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            n++;
        end
        check_output({tag, "_valid"}, {31'b0, id_valid_o}, 32'd1);
        check_output({tag, "_pc"}, id_pc_o, want_pc);
    endtask

    initial begin
        int          first_valid;
        int          valid_run;
        int          n;
        logic [31:0] frozen_pc;
        logic [31:0] got;
        logic [31:0] wrap_exp [3];

        checks        = 0;
        errors        = 0;
        cyc           = 0;
        lat_min       = 1;
        lat_max       = 1;
        inject_stray  = 1'b0;
        rst           = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Hold reset for a few cycles. The outputs must read zero.
        $display("[TB] reset state");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("reset_req", {31'b0, imem_req_o}, 32'd0);
        check_output("reset_valid", {31'b0, id_valid_o}, 32'd0);

        // Release reset with 1-cycle memory. The first valid word must
        // appear in cycle 3, and then one word must arrive every cycle.
        $display("[TB] reset release, 1-cycle memory");
        rst         = 1'b1;
        first_valid = -1;
        valid_run   = 0;
        for (int k = 0; k < 12; k++) begin
            if (id_valid_o === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                valid_run++;
            end
            apply_stimulus(1'b0, 1'b0, 32'h0);
        end
        check_output("first_valid_cycle", first_valid, 3);
        check_output("throughput", valid_run, 9);

        // A long stall. Decode freezes, and issue stops at full credit.
        $display("[TB] stall 10 cycles");
        frozen_pc = id_pc_o;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("stall_req_stopped", {31'b0, imem_req_o}, 32'd0);
        check_output("stall_freeze_pc", id_pc_o, frozen_pc);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("stall_resume_pc", id_pc_o, frozen_pc + 32'd4);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 32'h0);

        // Redirect with three requests in flight to 3-cycle memory.
        $display("[TB] redirect with 3 in flight");
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (pend.size() != 3 && n < 20) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            n++;
        end
        check_output("inflight3_reached", pend.size(), 3);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0100);
        wait_valid("redirect100", 32'h0000_0100);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 32'h0);

        // Redirect in the same cycle that an ack arrives.
        $display("[TB] redirect coinciding with ack");
        lat_min = 2;
        lat_max = 2;
        n = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            n++;
        end
        apply_stimulus(1'b0, 1'b1, 32'h0000_0200);
        wait_valid("redirect200", 32'h0000_0200);

        // Redirect near the top of the address space. Fetch must wrap to 0.
        $display("[TB] address wrap");
        lat_min = 1;
        lat_max = 1;
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        req_log.delete();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            got = (i < req_log.size()) ? req_log[i] : 32'hXXXX_XXXX;
            check_output("wrap_addr", got, wrap_exp[i]);
        end

        // Reset mid-stream with acks pending. The outputs clear at once.
        // A stray ack after release is ignored, and fetch restarts at the
        // reset PC.
        $display("[TB] reset mid-stream");
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_output("async_req", {31'b0, imem_req_o}, 32'd0);
        check_output("async_valid", {31'b0, id_valid_o}, 32'd0);
        check_output("async_pc", id_pc_o, 32'd0);
        check_output("async_inst", id_inst_o, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
        rst          = 1'b1;
        inject_stray = 1'b1;
        req_log.delete();
        apply_stimulus(1'b0, 1'b0, 32'h0);
        got = (req_log.size() > 0) ? req_log[0] : 32'hXXXX_XXXX;
        check_output("restart_addr", got, RESET_PC);
        wait_valid("restart", RESET_PC);

        // Randomized phase: stalls, redirects and memory latencies.
        $display("[TB] random phase");
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            bit          st;
            bit          rd;
            logic [31:0] tgt;
            st  = ($urandom_range(99, 0) < 30);
            rd  = ($urandom_range(99, 0) < 4);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                              : ($urandom() & 32'hFFFF_FFFC);
            apply_stimulus(st, rd, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
